key_display_ctrl: RTL and testbench
===================================

KEY_DISPLAY_CTRL -- requirements
Module: key_display_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_CNT, default 24000: clk cycles each digit is lit (about 0.5 ms at 48 MHz).
REQ-002 The block SHALL have parameter BLANK_CNT, default 480: clk cycles both digits are dark between digit phases (anti-ghosting).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port key_valid, input, 1 bit: debounced key-held level from the upstream keypad scanner, synchronous to clk.
REQ-006 The block SHALL have port key_value, input, 4 bits: hex code of the held key; valid only while key_valid=1.
REQ-007 The block SHALL have port seg, output, 7 bits: segments a..g as seg[0]..seg[6], active-low.
REQ-008 The block SHALL have port an, output, 2 bits: digit enables, active-low; an[0] is the newest-key digit, an[1] the older-key digit.
REQ-009 The block SHALL have port digit_new, output, 4 bits: most recent accepted key.
REQ-010 The block SHALL have port digit_old, output, 4 bits: previously accepted key.
REQ-011 The block SHALL have port key_accept, output, 1 bit: single-cycle pulse marking each accepted key.

Function
REQ-012 The block SHALL register key_valid once (kv_q) and accept a key only in a cycle where key_valid=1 and kv_q=0.
REQ-013 On acceptance, the block SHALL load digit_old<=digit_new and digit_new<=key_value on the same clock edge, and assert key_accept for exactly that following cycle.
REQ-014 A key held for any length of time SHALL cause exactly one acceptance; a new acceptance SHALL need key_valid to return to 0 for at least one cycle.
REQ-015 key_value SHALL be ignored in every cycle without acceptance.
REQ-016 The display FSM SHALL have states SHOW_NEW, BLANK_A, SHOW_OLD and BLANK_B, cycling in that order.
REQ-017 A single down-counter SHALL time the FSM: load REFRESH_CNT-1 on entering a SHOW state and BLANK_CNT-1 on entering a BLANK state, then advance to the next state in the cycle the counter reads 0.
REQ-018 If BLANK_CNT=0, the BLANK states SHALL be skipped, giving SHOW_NEW <-> SHOW_OLD.
REQ-019 In SHOW_NEW the outputs SHALL be an=2'b10 and seg=decode(digit_new); in SHOW_OLD, an=2'b01 and seg=decode(digit_old); in BLANK states, an=2'b11 and seg=7'h7F.
REQ-020 an and seg SHALL be registered so they change together and never show one digit's segments with the other digit's enable.
REQ-021 The decode SHALL map all 16 hex values 0-F to standard glyphs (b and d lower-case), e.g. 0->7'h40, 8->7'h00 (active-low, g=MSB).
REQ-022 Acceptance SHALL not disturb FSM timing; a digit lit in the cycle after acceptance SHALL show the updated value.
REQ-023 The counter width SHALL be $clog2(max(REFRESH_CNT,BLANK_CNT,2)) bits, and the counter SHALL never wrap below 0.

Reset
REQ-024 While reset=0 at a clock edge, the block SHALL force digit_new=0, digit_old=0, kv_q=1, key_accept=0, state=SHOW_NEW, counter=REFRESH_CNT-1, an=2'b11 and seg=7'h7F.
REQ-025 Setting kv_q=1 at reset SHALL ensure a key already held when reset releases is not accepted until it is released and pressed again.
REQ-026 Reset asserted mid-phase or in the same cycle as a key edge SHALL take priority, with no acceptance.

Structure
REQ-027 The state typedef (SHOW_NEW, BLANK_A, SHOW_OLD, BLANK_B) and the SEG_BLANK constant SHALL be defined in the shared package key_pkg.
REQ-028 The hex-to-seven-segment decode SHALL be a separate combinational sub-module, seg_decoder (4-bit in, 7-bit active-low out), instantiated once on the selected digit.

Verification (bench parameters REFRESH_CNT=4, BLANK_CNT=1)
REQ-029 Reset release with key_valid=0 -> an=11 for the first cycle, then the pattern 10 x4, 11 x1, 01 x4, 11 x1, repeating; seg=7'h40 whenever a digit is lit.
REQ-030 Press 5 (key_valid high for 50 cycles), release, then press A -> key_accept pulses twice, 1 cycle each; final digit_new=A, digit_old=5; seg shows 7'h12 on an=01 and 7'h08 on an=10.
REQ-031 key_valid held 1 across reset release -> no key_accept until key_valid falls and rises again.
REQ-032 Key edge in the last SHOW_NEW cycle -> phase lengths unchanged; the next SHOW_NEW shows the new digit; no cycle has an=10 with old segments.
REQ-033 Reset pulsed during SHOW_OLD after digits 3,7 -> digits return to 0 and the pattern restarts exactly as in REQ-029.
REQ-034 Sweep key_value 0-F with 16 separate presses -> each seg value matches the seg_decoder table, with digit_old trailing digit_new by one press.

Source files
------------

// File: rtl/key_pkg.sv
//------------------------------------------------------------------------------
// key_pkg
// Shared display-FSM state type, segment/anode constants and a sizing helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package key_pkg;

  typedef enum logic [1:0] {
    SHOW_NEW = 2'd0,
    BLANK_A  = 2'd1,
    SHOW_OLD = 2'd2,
    BLANK_B  = 2'd3
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_NEW    = 2'b10;
  localparam logic [1:0] AN_OLD    = 2'b01;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decoder.sv
//------------------------------------------------------------------------------
// seg_decoder
// Hex to active-low seven-segment glyphs, seg[0]=a .. seg[6]=g.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_decoder
  import key_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;  // lower-case b
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;  // lower-case d
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/key_display_ctrl.sv
//------------------------------------------------------------------------------
// key_display_ctrl
// Captures key presses into a two-deep history and multiplexes both digits.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_display_ctrl
  import key_pkg::*;
#(
  parameter int REFRESH_CNT = 24000,
  parameter int BLANK_CNT   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_accept
);

  localparam int              CW         = $clog2(max3(REFRESH_CNT, BLANK_CNT, 2));
  localparam bit              HAS_BLANK  = (BLANK_CNT > 0);
  localparam logic [CW-1:0]   SHOW_LOAD  = CW'(REFRESH_CNT - 1);
  localparam logic [CW-1:0]   BLANK_LOAD = CW'(HAS_BLANK ? BLANK_CNT - 1 : 0);

  logic          kv_q;
  logic          accept_q;
  logic [3:0]    digit_new_q, digit_new_d;
  logic [3:0]    digit_old_q, digit_old_d;
  disp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    sel_digit;
  logic [6:0]    dec_seg;
  logic          accept;

  assign accept = key_valid & ~kv_q;

  always_comb begin
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    if (accept) begin
      digit_new_d = key_value;
      digit_old_d = digit_new_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    if (cnt_q == '0) begin
      case (state_q)
        SHOW_NEW: begin
          state_d = HAS_BLANK ? BLANK_A : SHOW_OLD;
          cnt_d   = HAS_BLANK ? BLANK_LOAD : SHOW_LOAD;
        end
        BLANK_A: begin
          state_d = SHOW_OLD;
          cnt_d   = SHOW_LOAD;
        end
        SHOW_OLD: begin
          state_d = HAS_BLANK ? BLANK_B : SHOW_NEW;
          cnt_d   = HAS_BLANK ? BLANK_LOAD : SHOW_LOAD;
        end
        BLANK_B: begin
          state_d = SHOW_NEW;
          cnt_d   = SHOW_LOAD;
        end
      endcase
    end
  end

  // Decode from the post-acceptance digits so a freshly accepted key is shown at once.
  assign sel_digit = (state_q == SHOW_OLD) ? digit_old_d : digit_new_d;

  seg_decoder u_dec (
    .hex_i (sel_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    case (state_q)
      SHOW_NEW: begin
        an_d  = AN_NEW;
        seg_d = dec_seg;
      end
      SHOW_OLD: begin
        an_d  = AN_OLD;
        seg_d = dec_seg;
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      kv_q        <= 1'b1;
      accept_q    <= 1'b0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
      state_q     <= SHOW_NEW;
      cnt_q       <= SHOW_LOAD;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
    end else begin
      kv_q        <= key_valid;
      accept_q    <= accept;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_new  = digit_new_q;
  assign digit_old  = digit_old_q;
  assign key_accept = accept_q;

endmodule

`default_nettype wire

// File: tb/tb_key_display_ctrl.sv
//------------------------------------------------------------------------------
// tb_key_display_ctrl
// Randomized presses against a cycle-position reference model with a scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_display_ctrl;

  localparam int R = 4;
  localparam int B = 1;
  localparam int P = 2 * R + 2 * B;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_value = 4'h0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_accept;

  always #5 clk = ~clk;

  key_display_ctrl #(.REFRESH_CNT(R), .BLANK_CNT(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_value  (key_value),
    .seg        (seg),
    .an         (an),
    .digit_new  (digit_new),
    .digit_old  (digit_old),
    .key_accept (key_accept)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: digit history plus position in the refresh period.
  typedef struct packed { logic [3:0] nw; logic [3:0] od; } pair_t;
  pair_t      sb_q[$];
  logic [3:0] m_new  = 4'h0;
  logic [3:0] m_old  = 4'h0;
  logic       m_prev = 1'b1;
  int         m_k    = 0;
  logic [1:0] e_an   = 2'b11;
  logic [6:0] e_seg  = 7'h7F;
  logic       e_acc  = 1'b0;

  function automatic logic [1:0] pat_an(input int k);
    int p;
    p = k % P;
    if (p < R)         return 2'b10;
    if (p < R + B)     return 2'b11;
    if (p < 2 * R + B) return 2'b01;
    return 2'b11;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_new = 4'h0; m_old = 4'h0; m_prev = 1'b1; m_k = 0;
      e_an = 2'b11; e_seg = 7'h7F; e_acc = 1'b0;
    end else begin
      e_acc = 1'b0;
      if (key_valid && !m_prev) begin
        m_old = m_new;
        m_new = key_value;
        sb_q.push_back({m_new, m_old});
        e_acc = 1'b1;
      end
      m_prev = key_valid;
      e_an   = pat_an(m_k);
      e_seg  = (e_an == 2'b10) ? DEC[m_new] : (e_an == 2'b01) ? DEC[m_old] : 7'h7F;
      m_k++;
    end
  end

  always @(negedge clk) begin
    pair_t exp_p;
    chk("an", {6'b0, an}, {6'b0, e_an});
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("key_accept", {7'b0, key_accept}, {7'b0, e_acc});
    if (key_accept === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_accept", 8'd1, 8'd0);
      end else begin
        exp_p = sb_q.pop_front();
        chk("digit_new", {4'b0, digit_new}, {4'b0, exp_p.nw});
        chk("digit_old", {4'b0, digit_old}, {4'b0, exp_p.od});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      key_value = 4'($urandom);
    end
  endtask

  task automatic press(input logic [3:0] v, input int hold, input int gap);
    @(negedge clk);
    key_valid = 1'b1;
    key_value = v;
    repeat (hold - 1) begin
      @(negedge clk);
      key_value = 4'($urandom);
    end
    @(negedge clk);
    key_valid = 1'b0;
    idle(gap - 1);
  endtask

  task automatic wait_an(input logic [1:0] target);
    int w;
    w = 0;
    while (an !== target && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("wait_an_timeout", 8'd1, 8'd0);
  endtask

  initial begin
    // Reset with no key, then free-running refresh pattern.
    idle(3);
    reset = 1'b1;
    idle(30);

    // Press 5 for 50 cycles, release, press A.
    press(4'h5, 50, 6);
    press(4'hA, 8, 12);
    chk("final_new_A", {4'b0, digit_new}, 8'h0A);
    chk("final_old_5", {4'b0, digit_old}, 8'h05);
    wait_an(2'b01);
    chk("seg_old_5", {1'b0, seg}, 8'h12);
    wait_an(2'b10);
    chk("seg_new_A", {1'b0, seg}, 8'h08);

    // Reset asserted together with a key edge, key still held at release.
    @(negedge clk);
    reset = 1'b0;
    key_valid = 1'b1;
    key_value = 4'h9;
    idle(3);
    reset = 1'b1;
    idle(20);
    chk("held_no_accept_new", {4'b0, digit_new}, 8'h00);
    @(negedge clk);
    key_valid = 1'b0;
    idle(3);
    press(4'hC, 3, 5);
    chk("held_then_repress", {4'b0, digit_new}, 8'h0C);

    // Key edges aligned to the end of SHOW_NEW at a range of offsets.
    for (int off = 0; off < P; off++) begin
      wait_an(2'b11);
      wait_an(2'b10);
      idle(off);
      press(4'($urandom), 1 + off % 3, 2);
    end

    // Reset pulsed during SHOW_OLD after digits 3 and 7.
    press(4'h3, 4, 4);
    press(4'h7, 4, 4);
    wait_an(2'b01);
    idle(1);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2 * P + 2);
    chk("reset_clears_new", {4'b0, digit_new}, 8'h00);
    chk("reset_clears_old", {4'b0, digit_old}, 8'h00);

    // Sweep every hex value.
    for (int v = 0; v < 16; v++) press(4'(v), 2 + v % 4, 3 + v % 5);

    // Random presses, including single-cycle holds and gaps.
    for (int i = 0; i < 200; i++)
      press(4'($urandom), $urandom_range(1, 12), $urandom_range(1, 12));
    idle(2 * P);

    chk("scoreboard_empty", 8'(sb_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
